// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM state
// encoding, instruction/byte widths and byte-lane positions within inst.
package fetch_sequencer_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_F_OP  = 3'd1;
  localparam logic [2:0] ST_F_A1  = 3'd2;
  localparam logic [2:0] ST_F_A2  = 3'd3;
  localparam logic [2:0] ST_VALID = 3'd4;

  localparam int INST_W = 24;
  localparam int BYTE_W = 8;

  // Bit offsets of each byte inside the assembled instruction word
  localparam int OP_LSB = 16;
  localparam int A1_LSB = 8;
  localparam int A2_LSB = 0;

endpackage

// File: rtl/fetch_sequencer_pc.sv
// Program counter for the fetch sequencer: loads RESET_PC on reset,
// takes a redirect target, or steps by one with natural modulo wrap.
module fetch_sequencer_pc #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] target,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  // Redirect has priority over increment; the +1 wraps at 2**ADDR_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch controller: reads opcode/operand1/operand2 bytes from
// program memory at pc, pc+1, pc+2, assembles a 24-bit word and offers it
// to decode with valid/ready. A pc_load redirect overrides everything else
// in the same cycle, including a completing read or a decode acceptance.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [BYTE_W-1:0] mem_data,
  input  logic              mem_ready,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  output logic [ADDR_W-1:0] pc
);

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       fetching;
  logic       byte_take;

  // Outputs decode directly from the state register, so an async reset
  // drops mem_rd and inst_valid in the same cycle it is asserted.
  assign fetching   = (state_q == ST_F_OP) || (state_q == ST_F_A1) || (state_q == ST_F_A2);
  assign mem_rd     = fetching;
  assign inst_valid = (state_q == ST_VALID);
  assign mem_addr   = pc;

  // A read completing under a redirect is discarded: no byte, no increment
  assign byte_take  = fetching && mem_ready && !pc_load;

  fetch_sequencer_pc #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (pc_load),
    .target (pc_target),
    .inc    (byte_take),
    .pc     (pc)
  );

  // Next-state logic; run=0 only takes effect at an instruction boundary
  always_comb begin
    state_d = state_q;
    if (pc_load) begin
      state_d = run ? ST_F_OP : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (run)        state_d = ST_F_OP;
        ST_F_OP:  if (mem_ready)  state_d = ST_F_A1;
        ST_F_A1:  if (mem_ready)  state_d = ST_F_A2;
        ST_F_A2:  if (mem_ready)  state_d = ST_VALID;
        ST_VALID: if (inst_ready) state_d = run ? ST_F_OP : ST_IDLE;
        default:                  state_d = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Byte assembly: each fetch state owns one lane; untouched lanes keep old data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst <= '0;
    end else if (byte_take) begin
      case (state_q)
        ST_F_OP: inst[OP_LSB +: BYTE_W] <= mem_data;
        ST_F_A1: inst[A1_LSB +: BYTE_W] <= mem_data;
        ST_F_A2: inst[A2_LSB +: BYTE_W] <= mem_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer with a combinational program memory.
module tb_fetch_sequencer;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              run;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_ready;
  logic [23:0]       inst;
  logic              inst_valid;
  logic              inst_ready;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_target;
  logic [ADDR_W-1:0] pc;

  logic [7:0] mem [256];

  int n_total = 0;
  int n_pass  = 0;

  fetch_sequencer #(.ADDR_W(ADDR_W), .RESET_PC(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .inst       (inst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .pc_load    (pc_load),
    .pc_target  (pc_target),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  assign mem_data = mem[mem_addr];

  typedef struct {
    logic        do_load;
    logic [7:0]  start;
    int          stall;
    logic [23:0] exp_inst;
    logic [7:0]  exp_pc;
    int          exp_lat;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [23:0] held;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'hA0; mem[8'h01] = 8'h11; mem[8'h02] = 8'h22;
    mem[8'h03] = 8'h33; mem[8'h04] = 8'h44; mem[8'h05] = 8'h55;
    mem[8'hFE] = 8'hC1; mem[8'hFF] = 8'hC2;
    mem[8'h40] = 8'h5A; mem[8'h41] = 8'h6B; mem[8'h42] = 8'h7C;
    mem[8'h43] = 8'h8D; mem[8'h44] = 8'h9E; mem[8'h45] = 8'hAF;
    mem[8'h46] = 8'h12; mem[8'h47] = 8'h34;

    //           load  start  stall inst        pc     lat
    vecs[0] = '{1'b0, 8'h03, 0, 24'h334455, 8'h06, 3};
    vecs[1] = '{1'b1, 8'h00, 2, 24'hA01122, 8'h03, 5};
    vecs[2] = '{1'b1, 8'hFE, 0, 24'hC1C2A0, 8'h01, 3};
    vecs[3] = '{1'b1, 8'h40, 1, 24'h5A6B7C, 8'h43, 4};
    vecs[4] = '{1'b0, 8'h43, 0, 24'h8D9EAF, 8'h46, 3};

    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b1; inst_ready = 1'b0;
    pc_load = 1'b0; pc_target = '0;
    tick(); tick();
    check("reset_mem_rd", 32'(mem_rd), 32'd0);
    check("reset_valid",  32'(inst_valid), 32'd0);
    check("reset_pc",     32'(pc), 32'h00);
    check("reset_inst",   32'(inst), 32'h0);
    rst_n = 1'b1;
    tick(); tick();
    check("idle_no_rd", 32'(mem_rd), 32'd0);

    // Basic fetch from IDLE: valid 4 clocks after run
    run = 1'b1;
    n = 0;
    while (inst_valid !== 1'b1 && n < 20) begin tick(); n++; end
    check("s1_latency", 32'(n), 32'd4);
    check("s1_inst",    32'(inst), 32'hA01122);
    check("s1_pc",      32'(pc), 32'h03);

    // Decode back-pressure: everything holds while inst_ready is low
    held = inst;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s3_hold_valid", 32'(inst_valid), 32'd1);
      check("s3_hold_inst",  32'(inst), 32'(held));
      check("s3_hold_rd",    32'(mem_rd), 32'd0);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("s3_valid_drop", 32'(inst_valid), 32'd0);
    check("s3_next_rd",    32'(mem_rd), 32'd1);
    check("s3_next_addr",  32'(mem_addr), 32'h03);

    // Table-driven fetches, each starting in F_OP
    for (int v = 0; v < 5; v++) begin
      int k;
      if (vecs[v].do_load) begin
        pc_load = 1'b1; pc_target = vecs[v].start; mem_ready = 1'b1;
        tick();
        pc_load = 1'b0;
        check("vec_load_valid", 32'(inst_valid), 32'd0);
      end
      check("vec_start_addr", 32'(mem_addr), 32'(vecs[v].start));
      k = 0;
      while (inst_valid !== 1'b1 && k < 20) begin
        if (k >= 1 && k <= vecs[v].stall) begin
          logic [7:0] a1;
          a1 = vecs[v].start + 8'd1;
          mem_ready = 1'b0;
          check("vec_stall_rd",   32'(mem_rd), 32'd1);
          check("vec_stall_addr", 32'(mem_addr), 32'(a1));
        end else begin
          mem_ready = 1'b1;
        end
        tick();
        k++;
      end
      mem_ready = 1'b1;
      check("vec_latency", 32'(k), 32'(vecs[v].exp_lat));
      check("vec_inst",    32'(inst), 32'(vecs[v].exp_inst));
      check("vec_pc",      32'(pc), 32'(vecs[v].exp_pc));
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      check("vec_accept", 32'(inst_valid), 32'd0);
    end

    // Redirect in F_A1 with a simultaneous mem_ready drops the byte
    tick();  // F_OP at 0x46 takes 0x12 into opcode lane
    check("s5_in_a1_pc", 32'(pc), 32'h47);
    pc_load = 1'b1; pc_target = 8'h40; mem_ready = 1'b1;
    tick();
    pc_load = 1'b0;
    check("s5_addr",  32'(mem_addr), 32'h40);
    check("s5_rd",    32'(mem_rd), 32'd1);
    check("s5_valid", 32'(inst_valid), 32'd0);
    check("s5_inst",  32'(inst), 32'h129EAF);
    tick(); tick(); tick();
    check("s5_refetch_valid", 32'(inst_valid), 32'd1);
    check("s5_refetch_inst",  32'(inst), 32'h5A6B7C);

    // Redirect wins over acceptance in VALID
    pc_load = 1'b1; pc_target = 8'h00; inst_ready = 1'b1;
    tick();
    pc_load = 1'b0; inst_ready = 1'b0;
    check("s5b_valid", 32'(inst_valid), 32'd0);
    check("s5b_pc",    32'(pc), 32'h00);
    check("s5b_rd",    32'(mem_rd), 32'd1);

    // Async reset in F_A2 takes effect without a clock edge
    tick(); tick();
    check("s6_in_a2_pc", 32'(pc), 32'h02);
    rst_n = 1'b0;
    #1;
    check("s6_rst_rd",    32'(mem_rd), 32'd0);
    check("s6_rst_valid", 32'(inst_valid), 32'd0);
    check("s6_rst_pc",    32'(pc), 32'h00);
    #1;
    rst_n = 1'b1;
    tick();  // IDLE -> F_OP with run=1
    check("s6_restart_rd", 32'(mem_rd), 32'd1);

    // run=0 mid-fetch: instruction completes, then IDLE after acceptance
    run = 1'b0;
    tick(); tick(); tick();
    check("s6_run0_valid", 32'(inst_valid), 32'd1);
    check("s6_run0_inst",  32'(inst), 32'hA01122);
    check("s6_run0_pc",    32'(pc), 32'h03);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check("s6_idle_valid", 32'(inst_valid), 32'd0);
    check("s6_idle_rd",    32'(mem_rd), 32'd0);
    tick(); tick();
    check("s6_idle_stay_rd", 32'(mem_rd), 32'd0);
    check("s6_idle_stay_pc", 32'(pc), 32'h03);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
